// File: rtl/game_pkg.sv
// Shared definitions for the warships main controller: board cell codes,
// controller state encoding and the "no selection" cords test.
package game_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_HIT   = 2'b10;
    localparam logic [1:0] CELL_MISS  = 2'b11;

    // Codes are visible on state_out and must stay fixed.
    typedef enum logic [3:0] {
        ST_DEPLOY       = 4'd0,
        ST_DEPLOY_CHECK = 4'd1,
        ST_WAIT_START   = 4'd2,
        ST_WAIT_PEER    = 4'd3,
        ST_WAIT_ENEMY   = 4'd4,
        ST_MEM_CHECK    = 4'd5,
        ST_ANSWER       = 4'd6,
        ST_WAIT_SHOT    = 4'd7,
        ST_SHOT_CHECK   = 4'd8,
        ST_WAIT_ANSWER  = 4'd9,
        ST_SAVE_RESULT  = 4'd10,
        ST_WIN          = 4'd11,
        ST_LOSE         = 4'd12
    } state_e;

    localparam int MAX_CORDS_W = 32;

    // True when the low cords_w bits are all ones ("no selection").
    // Callers zero-extend their cords to MAX_CORDS_W bits.
    function automatic logic is_no_cord(input logic [MAX_CORDS_W-1:0] cords,
                                        input int cords_w);
        logic all_ones;
        all_ones = 1'b1;
        for (int i = 0; i < MAX_CORDS_W; i++) begin
            if (i < cords_w) all_ones = all_ones & cords[i];
        end
        return all_ones;
    endfunction

endpackage

// File: rtl/game_fsm_turn_timer.sv
// Answer-timeout timer: down-counter reloaded on clear or on expiry,
// expire is high for the single enabled cycle in which the count is zero.
module turn_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    assign expire_o = enable_i && (cnt_q == '0);

    // Count down while enabled; restart the period on clear or expiry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= RELOAD;
        end else if (clear_i || expire_o) begin
            cnt_q <= RELOAD;
        end else if (enable_i) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_fsm.sv
// Warships main controller: ship deployment, turn protocol with the peer
// board and hit bookkeeping in the own and enemy board memories.
//
// state          | meaning
// ---------------+------------------------------------------------------
// DEPLOY         | waiting for a click on own board to place a ship
// DEPLOY_CHECK   | own cell read back; place ship only if cell empty
// WAIT_START     | all ships placed, start button enabled
// WAIT_PEER      | start sent, waiting for the peer to be ready
// WAIT_ENEMY     | enemy's turn, waiting for its shot
// MEM_CHECK      | own cell under enemy shot read back; mark hit/miss
// ANSWER         | answer strobe out; lose if no ships remain
// WAIT_SHOT      | our turn, waiting for a click on the enemy board
// SHOT_CHECK     | enemy cell read back; fire only at an unknown cell
// WAIT_ANSWER    | shot sent, waiting for the answer (retransmit on timeout)
// SAVE_RESULT    | record answer in enemy board; win if enemy has no ships
// WIN / LOSE     | terminal until reset
module game_fsm
    import game_pkg::*;
#(
    parameter int CORD_W         = 4,
    parameter int SHIPS_NUMBER   = 10,
    parameter int FIRST_SHOT     = 1,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CTR_W          = $clog2(SHIPS_NUMBER + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*CORD_W-1:0]   my_grid_cords,
    input  logic [2*CORD_W-1:0]   en_grid_cords,
    output logic [2*CORD_W-1:0]   my_mem_addr,
    input  logic [1:0]            my_mem_data_in,
    output logic [1:0]            my_mem_data_out,
    output logic                  my_mem_w_nr,
    output logic [2*CORD_W-1:0]   en_mem_addr,
    input  logic [1:0]            en_mem_data_in,
    output logic [1:0]            en_mem_data_out,
    output logic                  en_mem_w_nr,
    input  logic [2*CORD_W-1:0]   ship_cords_in,
    input  logic                  hit2,
    input  logic                  ready2,
    output logic [2*CORD_W-1:0]   ship_cords_out,
    output logic                  hit1,
    output logic                  ready1,
    input  logic                  start_btn,
    output logic                  start_btn_en,
    output logic                  my_turn,
    output logic                  en_turn,
    output logic                  win,
    output logic                  lose,
    output logic [CTR_W-1:0]      my_ctr,
    output logic [CTR_W-1:0]      en_ctr,
    output logic [3:0]            state_out
);
    localparam int CW = 2 * CORD_W;
    localparam logic [CW-1:0]    NO_CORD = {CW{1'b1}};
    localparam logic [CTR_W-1:0] SHIPS   = CTR_W'(SHIPS_NUMBER);

    state_e           state_q, state_d;
    logic             peer_ready_q, peer_ready_d;
    logic [CW-1:0]    shot_q, shot_d;
    logic             hit2_q, hit2_d;
    logic [CW-1:0]    my_addr_q, my_addr_d;
    logic [1:0]       my_wdata_q, my_wdata_d;
    logic             my_we_q, my_we_d;
    logic [CW-1:0]    en_addr_q, en_addr_d;
    logic [1:0]       en_wdata_q, en_wdata_d;
    logic             en_we_q, en_we_d;
    logic [CW-1:0]    cords_out_q, cords_out_d;
    logic             hit1_q, hit1_d;
    logic             ready1_q, ready1_d;
    logic             start_en_q, start_en_d;
    logic             my_turn_q, my_turn_d;
    logic             en_turn_q, en_turn_d;
    logic             win_q, win_d;
    logic             lose_q, lose_d;
    logic [CTR_W-1:0] my_ctr_q, my_ctr_d;
    logic [CTR_W-1:0] en_ctr_q, en_ctr_d;

    logic my_none, en_none, pre_game;
    logic timer_clr, timer_en, timer_exp;

    assign my_none  = is_no_cord(MAX_CORDS_W'(my_grid_cords), CW);
    assign en_none  = is_no_cord(MAX_CORDS_W'(en_grid_cords), CW);
    assign pre_game = (state_q == ST_DEPLOY) || (state_q == ST_DEPLOY_CHECK) ||
                      (state_q == ST_WAIT_START) || (state_q == ST_WAIT_PEER);
    assign timer_en = (state_q == ST_WAIT_ANSWER);

    turn_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_turn_timer (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (timer_clr),
        .enable_i(timer_en),
        .expire_o(timer_exp)
    );

    // Next-state, memory access, strobe and counter decisions.
    always_comb begin
        state_d      = state_q;
        peer_ready_d = peer_ready_q;
        shot_d       = shot_q;
        hit2_d       = hit2_q;
        my_addr_d    = my_addr_q;
        my_wdata_d   = my_wdata_q;
        my_we_d      = 1'b0;
        en_addr_d    = en_addr_q;
        en_wdata_d   = en_wdata_q;
        en_we_d      = 1'b0;
        cords_out_d  = cords_out_q;
        hit1_d       = hit1_q;
        ready1_d     = 1'b0;
        my_ctr_d     = my_ctr_q;
        en_ctr_d     = en_ctr_q;
        timer_clr    = 1'b0;

        if (ready2 && pre_game) peer_ready_d = 1'b1;

        case (state_q)
            ST_DEPLOY: begin
                if (my_ctr_q >= SHIPS) begin
                    state_d = ST_WAIT_START;
                end else if (!my_none) begin
                    my_addr_d = my_grid_cords;
                    state_d   = ST_DEPLOY_CHECK;
                end
            end
            ST_DEPLOY_CHECK: begin
                if ((my_mem_data_in == CELL_EMPTY) && (my_ctr_q < SHIPS)) begin
                    my_we_d    = 1'b1;
                    my_wdata_d = CELL_SHIP;
                    my_ctr_d   = my_ctr_q + CTR_W'(1);
                end
                state_d = ST_DEPLOY;
            end
            ST_WAIT_START: begin
                if (start_btn) begin
                    ready1_d = 1'b1;
                    state_d  = ST_WAIT_PEER;
                end
            end
            ST_WAIT_PEER: begin
                if (peer_ready_q || ready2)
                    state_d = (FIRST_SHOT != 0) ? ST_WAIT_SHOT : ST_WAIT_ENEMY;
            end
            ST_WAIT_ENEMY: begin
                if (ready2) begin
                    shot_d    = ship_cords_in;
                    my_addr_d = ship_cords_in;
                    state_d   = ST_MEM_CHECK;
                end
            end
            ST_MEM_CHECK: begin
                // The answer strobe is issued here so that it is high in ANSWER.
                hit1_d      = 1'b0;
                ready1_d    = 1'b1;
                cords_out_d = shot_q;
                case (my_mem_data_in)
                    CELL_SHIP: begin
                        my_we_d    = 1'b1;
                        my_wdata_d = CELL_HIT;
                        hit1_d     = 1'b1;
                        if (my_ctr_q != '0) my_ctr_d = my_ctr_q - CTR_W'(1);
                    end
                    CELL_EMPTY: begin
                        my_we_d    = 1'b1;
                        my_wdata_d = CELL_MISS;
                    end
                    default: ;
                endcase
                state_d = ST_ANSWER;
            end
            ST_ANSWER: begin
                state_d = (my_ctr_q == '0) ? ST_LOSE : ST_WAIT_SHOT;
            end
            ST_WAIT_SHOT: begin
                if (!en_none) begin
                    en_addr_d = en_grid_cords;
                    state_d   = ST_SHOT_CHECK;
                end
            end
            ST_SHOT_CHECK: begin
                if (en_mem_data_in == CELL_EMPTY) begin
                    cords_out_d = en_addr_q;
                    ready1_d    = 1'b1;
                    timer_clr   = 1'b1;
                    state_d     = ST_WAIT_ANSWER;
                end else begin
                    state_d = ST_WAIT_SHOT;
                end
            end
            ST_WAIT_ANSWER: begin
                if (ready2) begin
                    hit2_d  = hit2;
                    state_d = ST_SAVE_RESULT;
                end else if (timer_exp) begin
                    ready1_d = 1'b1;
                end
            end
            ST_SAVE_RESULT: begin
                en_we_d = 1'b1;
                if (hit2_q) begin
                    en_wdata_d = CELL_HIT;
                    if (en_ctr_q != '0) en_ctr_d = en_ctr_q - CTR_W'(1);
                end else begin
                    en_wdata_d = CELL_MISS;
                end
                state_d = (en_ctr_d == '0) ? ST_WIN : ST_WAIT_ENEMY;
            end
            ST_WIN, ST_LOSE: ;
            default: state_d = ST_DEPLOY;
        endcase

        // Level indicators follow the next state so they line up with state_out.
        start_en_d = (state_d == ST_WAIT_START);
        my_turn_d  = (state_d == ST_WAIT_SHOT);
        en_turn_d  = (state_d == ST_WAIT_ENEMY);
        win_d      = (state_d == ST_WIN);
        lose_d     = (state_d == ST_LOSE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_DEPLOY;
            peer_ready_q <= 1'b0;
            shot_q       <= NO_CORD;
            hit2_q       <= 1'b0;
            my_addr_q    <= NO_CORD;
            my_wdata_q   <= CELL_EMPTY;
            my_we_q      <= 1'b0;
            en_addr_q    <= NO_CORD;
            en_wdata_q   <= CELL_EMPTY;
            en_we_q      <= 1'b0;
            cords_out_q  <= NO_CORD;
            hit1_q       <= 1'b0;
            ready1_q     <= 1'b0;
            start_en_q   <= 1'b0;
            my_turn_q    <= 1'b0;
            en_turn_q    <= 1'b0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            my_ctr_q     <= '0;
            en_ctr_q     <= SHIPS;
        end else begin
            state_q      <= state_d;
            peer_ready_q <= peer_ready_d;
            shot_q       <= shot_d;
            hit2_q       <= hit2_d;
            my_addr_q    <= my_addr_d;
            my_wdata_q   <= my_wdata_d;
            my_we_q      <= my_we_d;
            en_addr_q    <= en_addr_d;
            en_wdata_q   <= en_wdata_d;
            en_we_q      <= en_we_d;
            cords_out_q  <= cords_out_d;
            hit1_q       <= hit1_d;
            ready1_q     <= ready1_d;
            start_en_q   <= start_en_d;
            my_turn_q    <= my_turn_d;
            en_turn_q    <= en_turn_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
            my_ctr_q     <= my_ctr_d;
            en_ctr_q     <= en_ctr_d;
        end
    end

    assign my_mem_addr     = my_addr_q;
    assign my_mem_data_out = my_wdata_q;
    assign my_mem_w_nr     = my_we_q;
    assign en_mem_addr     = en_addr_q;
    assign en_mem_data_out = en_wdata_q;
    assign en_mem_w_nr     = en_we_q;
    assign ship_cords_out  = cords_out_q;
    assign hit1            = hit1_q;
    assign ready1          = ready1_q;
    assign start_btn_en    = start_en_q;
    assign my_turn         = my_turn_q;
    assign en_turn         = en_turn_q;
    assign win             = win_q;
    assign lose            = lose_q;
    assign my_ctr          = my_ctr_q;
    assign en_ctr          = en_ctr_q;
    assign state_out       = state_q;

endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm: bench-owned board memories, hand-driven peer.
module tb_game_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] my_grid_cords = 8'hFF, en_grid_cords = 8'hFF;
    logic [7:0] my_mem_addr, en_mem_addr, ship_cords_out;
    logic [7:0] ship_cords_in = 8'h00;
    logic [1:0] my_mem_data_in, my_mem_data_out, en_mem_data_in, en_mem_data_out;
    logic       my_mem_w_nr, en_mem_w_nr;
    logic       hit2 = 1'b0, ready2 = 1'b0, start_btn = 1'b0;
    logic       hit1, ready1, start_btn_en, my_turn, en_turn, win, lose;
    logic [3:0] my_ctr, en_ctr, state_out;

    logic [1:0] my_mem [256];
    logic [1:0] en_mem [256];
    logic       mem_clr = 1'b0;
    int         my_wr_cnt = 0;
    int         r1_cnt = 0;

    int vec = 0, miss = 0;
    int exp_my = 0, exp_en = 10;

    always #5 clk = ~clk;

    game_fsm #(
        .CORD_W(4), .SHIPS_NUMBER(10), .FIRST_SHOT(1), .TIMEOUT_CYCLES(16), .CTR_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .my_grid_cords(my_grid_cords), .en_grid_cords(en_grid_cords),
        .my_mem_addr(my_mem_addr), .my_mem_data_in(my_mem_data_in),
        .my_mem_data_out(my_mem_data_out), .my_mem_w_nr(my_mem_w_nr),
        .en_mem_addr(en_mem_addr), .en_mem_data_in(en_mem_data_in),
        .en_mem_data_out(en_mem_data_out), .en_mem_w_nr(en_mem_w_nr),
        .ship_cords_in(ship_cords_in), .hit2(hit2), .ready2(ready2),
        .ship_cords_out(ship_cords_out), .hit1(hit1), .ready1(ready1),
        .start_btn(start_btn), .start_btn_en(start_btn_en),
        .my_turn(my_turn), .en_turn(en_turn), .win(win), .lose(lose),
        .my_ctr(my_ctr), .en_ctr(en_ctr), .state_out(state_out)
    );

    assign my_mem_data_in = my_mem[my_mem_addr];
    assign en_mem_data_in = en_mem[en_mem_addr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) begin
                my_mem[i] <= 2'b00;
                en_mem[i] <= 2'b00;
            end
        end else begin
            if (my_mem_w_nr) begin
                my_mem[my_mem_addr] <= my_mem_data_out;
                my_wr_cnt <= my_wr_cnt + 1;
            end
            if (en_mem_w_nr) en_mem[en_mem_addr] <= en_mem_data_out;
        end
        if (ready1) r1_cnt <= r1_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic deploy(input logic [7:0] c);
        my_grid_cords = c;
        tick();
        my_grid_cords = 8'hFF;
        tick();
        tick();
    endtask

    task automatic restart_to_wait_peer;
        rst = 1'b1; mem_clr = 1'b1;
        tick();
        rst = 1'b0; mem_clr = 1'b0;
        for (int i = 0; i < 10; i++) deploy(8'(i));
        exp_my = 10; exp_en = 10;
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        tick();
    endtask

    task automatic our_shot(input logic [7:0] c, input logic h);
        en_grid_cords = c;
        tick();
        en_grid_cords = 8'hFF;
        tick();
        vec++;
        if ({ready1, ship_cords_out, state_out} !== {1'b1, c, 4'd9}) begin
            miss++;
            $display("FAIL shot_tx %h: got rdy=%b cords=%h st=%0d want 1 %h 9", c, ready1, ship_cords_out, state_out, c);
        end
        ship_cords_in = c; ready2 = 1'b1; hit2 = h;
        tick();
        ready2 = 1'b0; hit2 = 1'b0;
        vec++;
        if ({ready1, state_out} !== {1'b0, 4'd10}) begin
            miss++;
            $display("FAIL shot_rx %h: got rdy=%b st=%0d want 0 10", c, ready1, state_out);
        end
        tick();
        if (h && exp_en > 0) exp_en--;
        vec++;
        if ({en_mem_w_nr, en_mem_data_out, en_ctr, state_out} !==
            {1'b1, (h ? 2'b10 : 2'b11), 4'(exp_en), (exp_en == 0 ? 4'd11 : 4'd4)}) begin
            miss++;
            $display("FAIL save %h: got w=%b d=%b ctr=%0d st=%0d want ctr=%0d", c, en_mem_w_nr, en_mem_data_out, en_ctr, state_out, exp_en);
        end
        tick();
        vec++;
        if (en_mem[c] !== (h ? 2'b10 : 2'b11)) begin
            miss++;
            $display("FAIL en_cell %h: got %b want %b", c, en_mem[c], (h ? 2'b10 : 2'b11));
        end
    endtask

    task automatic enemy_shot(input logic [7:0] c, input logic exp_hit, input logic exp_wr);
        int w0;
        w0 = my_wr_cnt;
        vec++;
        if ({en_turn, state_out} !== {1'b1, 4'd4}) begin
            miss++;
            $display("FAIL en_turn %h: got en_turn=%b st=%0d want 1 4", c, en_turn, state_out);
        end
        ship_cords_in = c; ready2 = 1'b1;
        tick();
        ready2 = 1'b0; ship_cords_in = 8'h00;
        vec++;
        if ({state_out, my_mem_addr} !== {4'd5, c}) begin
            miss++;
            $display("FAIL mem_check %h: got st=%0d addr=%h want 5 %h", c, state_out, my_mem_addr, c);
        end
        tick();
        if (exp_hit) exp_my--;
        vec++;
        if ({state_out, ready1, hit1, ship_cords_out, my_mem_w_nr, my_ctr} !==
            {4'd6, 1'b1, exp_hit, c, exp_wr, 4'(exp_my)}) begin
            miss++;
            $display("FAIL answer %h: got st=%0d rdy=%b hit=%b cords=%h w=%b ctr=%0d want 6 1 %b %h %b %0d",
                     c, state_out, ready1, hit1, ship_cords_out, my_mem_w_nr, my_ctr, exp_hit, c, exp_wr, exp_my);
        end
        if (exp_wr) begin
            vec++;
            if (my_mem_data_out !== (exp_hit ? 2'b10 : 2'b11)) begin
                miss++;
                $display("FAIL answer_data %h: got %b want %b", c, my_mem_data_out, (exp_hit ? 2'b10 : 2'b11));
            end
        end
        tick();
        vec++;
        if ({state_out, ready1, my_turn, my_wr_cnt} !==
            {(exp_my == 0 ? 4'd12 : 4'd7), 1'b0, (exp_my != 0), w0 + (exp_wr ? 1 : 0)}) begin
            miss++;
            $display("FAIL after_answer %h: got st=%0d rdy=%b turn=%b writes=%0d want writes=%0d",
                     c, state_out, ready1, my_turn, my_wr_cnt - w0, (exp_wr ? 1 : 0));
        end
    endtask

    task automatic test_reset;
        logic [48:0] got;
        rst = 1'b1; mem_clr = 1'b1;
        tick();
        tick();
        mem_clr = 1'b0;
        got = {state_out, ship_cords_out, my_mem_addr, en_mem_addr, en_ctr, my_ctr,
               my_mem_data_out, my_mem_w_nr, en_mem_data_out, en_mem_w_nr,
               hit1, ready1, start_btn_en, my_turn, en_turn, win, lose};
        vec++;
        if (got !== {4'd0, 24'hFFFFFF, 4'd10, 4'd0, 13'd0}) begin
            miss++;
            $display("FAIL reset_values: got %h want %h", got, {4'd0, 24'hFFFFFF, 4'd10, 4'd0, 13'd0});
        end
        rst = 1'b0;
        tick();
        vec++;
        if ({state_out, my_ctr} !== {4'd0, 4'd0}) begin
            miss++;
            $display("FAIL idle_deploy: got st=%0d ctr=%0d want 0 0", state_out, my_ctr);
        end
    endtask

    task automatic test_deploy;
        int w0;
        for (int i = 0; i < 5; i++) deploy(8'(i));
        ready2 = 1'b1;
        tick();
        ready2 = 1'b0;
        w0 = my_wr_cnt;
        deploy(8'h03);
        vec++;
        if ({my_ctr, my_wr_cnt} !== {4'd5, w0}) begin
            miss++;
            $display("FAIL duplicate: got ctr=%0d writes=%0d want 5 0", my_ctr, my_wr_cnt - w0);
        end
        for (int i = 5; i < 10; i++) deploy(8'(i));
        vec++;
        if ({my_ctr, state_out, start_btn_en, my_wr_cnt} !== {4'd10, 4'd2, 1'b1, w0 + 5}) begin
            miss++;
            $display("FAIL deploy_done: got ctr=%0d st=%0d en=%b writes=%0d want 10 2 1 5",
                     my_ctr, state_out, start_btn_en, my_wr_cnt - w0);
        end
        vec++;
        if ({my_mem[0], my_mem[3], my_mem[9], my_mem[10]} !== 8'b01_01_01_00) begin
            miss++;
            $display("FAIL ship_cells: got %b %b %b %b want 01 01 01 00", my_mem[0], my_mem[3], my_mem[9], my_mem[10]);
        end
        deploy(8'h0A);
        vec++;
        if ({my_ctr, state_out, my_wr_cnt} !== {4'd10, 4'd2, w0 + 5}) begin
            miss++;
            $display("FAIL full_click: got ctr=%0d st=%0d writes=%0d want 10 2 5", my_ctr, state_out, my_wr_cnt - w0);
        end
    endtask

    task automatic test_start;
        int r0;
        r0 = r1_cnt;
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        vec++;
        if ({ready1, state_out} !== {1'b1, 4'd3}) begin
            miss++;
            $display("FAIL start_pulse: got rdy=%b st=%0d want 1 3", ready1, state_out);
        end
        tick();
        vec++;
        if ({state_out, my_turn, en_turn, ready1, start_btn_en, r1_cnt} !== {4'd7, 1'b1, 1'b0, 1'b0, 1'b0, r0 + 1}) begin
            miss++;
            $display("FAIL first_turn: got st=%0d my=%b en=%b rdy=%b sen=%b pulses=%0d want 7 1 0 0 0 1",
                     state_out, my_turn, en_turn, ready1, start_btn_en, r1_cnt - r0);
        end
    endtask

    task automatic test_timeout;
        int r0, early;
        en_grid_cords = 8'h11;
        tick();
        en_grid_cords = 8'hFF;
        tick();
        r0 = r1_cnt;
        vec++;
        if ({ready1, ship_cords_out, state_out} !== {1'b1, 8'h11, 4'd9}) begin
            miss++;
            $display("FAIL shot_11: got rdy=%b cords=%h st=%0d want 1 11 9", ready1, ship_cords_out, state_out);
        end
        early = 0;
        for (int j = 1; j < 16; j++) begin
            tick();
            if (ready1 !== 1'b0) early++;
        end
        vec++;
        if (early != 0) begin
            miss++;
            $display("FAIL early_retx: got %0d pulses want 0", early);
        end
        tick();
        vec++;
        if ({ready1, ship_cords_out, state_out} !== {1'b1, 8'h11, 4'd9}) begin
            miss++;
            $display("FAIL retx_16: got rdy=%b cords=%h st=%0d want 1 11 9", ready1, ship_cords_out, state_out);
        end
        for (int j = 17; j < 32; j++) tick();
        ready2 = 1'b1; hit2 = 1'b1; ship_cords_in = 8'h11;
        tick();
        ready2 = 1'b0; hit2 = 1'b0;
        vec++;
        if ({ready1, state_out, r1_cnt} !== {1'b0, 4'd10, r0 + 2}) begin
            miss++;
            $display("FAIL ready2_wins: got rdy=%b st=%0d pulses=%0d want 0 10 2", ready1, state_out, r1_cnt - r0);
        end
        tick();
        exp_en = 9;
        vec++;
        if ({en_mem_w_nr, en_mem_data_out, en_ctr, state_out} !== {1'b1, 2'b10, 4'd9, 4'd4}) begin
            miss++;
            $display("FAIL save_11: got w=%b d=%b ctr=%0d st=%0d want 1 10 9 4", en_mem_w_nr, en_mem_data_out, en_ctr, state_out);
        end
        tick();
        vec++;
        if (en_mem[8'h11] !== 2'b10) begin
            miss++;
            $display("FAIL en_cell_11: got %b want 10", en_mem[8'h11]);
        end
    endtask

    task automatic test_enemy_shots;
        int r0;
        exp_my = 10;
        enemy_shot(8'h05, 1'b1, 1'b1);
        vec++;
        if (my_mem[5] !== 2'b10) begin
            miss++;
            $display("FAIL my_cell_05: got %b want 10", my_mem[5]);
        end
        r0 = r1_cnt;
        en_grid_cords = 8'h11;
        tick();
        en_grid_cords = 8'hFF;
        tick();
        tick();
        vec++;
        if ({state_out, ready1, r1_cnt} !== {4'd7, 1'b0, r0}) begin
            miss++;
            $display("FAIL repeat_click: got st=%0d rdy=%b pulses=%0d want 7 0 0", state_out, ready1, r1_cnt - r0);
        end
        our_shot(8'h22, 1'b0);
        enemy_shot(8'h05, 1'b0, 1'b0);
        our_shot(8'h23, 1'b0);
        enemy_shot(8'h30, 1'b0, 1'b1);
        vec++;
        if (my_mem[8'h30] !== 2'b11) begin
            miss++;
            $display("FAIL my_cell_30: got %b want 11", my_mem[8'h30]);
        end
    endtask

    task automatic test_win;
        int r0;
        for (int i = 0; i < 8; i++) begin
            our_shot(8'h40 + 8'(i), 1'b1);
            enemy_shot(8'h31 + 8'(i), 1'b0, 1'b1);
        end
        our_shot(8'h50, 1'b1);
        r0 = r1_cnt;
        ready2 = 1'b1; en_grid_cords = 8'h51;
        tick();
        ready2 = 1'b0; en_grid_cords = 8'hFF;
        for (int j = 0; j < 3; j++) tick();
        vec++;
        if ({state_out, win, lose, my_turn, en_turn, ready1, en_ctr, r1_cnt} !==
            {4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, r0}) begin
            miss++;
            $display("FAIL win_hold: got st=%0d win=%b lose=%b turns=%b%b rdy=%b ctr=%0d want 11 1 0 00 0 0",
                     state_out, win, lose, my_turn, en_turn, ready1, en_ctr);
        end
    endtask

    task automatic test_lose;
        restart_to_wait_peer();
        tick();
        tick();
        vec++;
        if ({state_out, win} !== {4'd3, 1'b0}) begin
            miss++;
            $display("FAIL peer_wait: got st=%0d win=%b want 3 0", state_out, win);
        end
        ready2 = 1'b1;
        tick();
        ready2 = 1'b0;
        vec++;
        if ({state_out, my_turn} !== {4'd7, 1'b1}) begin
            miss++;
            $display("FAIL peer_go: got st=%0d turn=%b want 7 1", state_out, my_turn);
        end
        for (int i = 0; i < 10; i++) begin
            our_shot(8'h60 + 8'(i), 1'b0);
            enemy_shot(8'(i), 1'b1, 1'b1);
        end
        tick();
        tick();
        vec++;
        if ({state_out, lose, win, my_turn, en_turn, ready1, my_ctr, en_ctr} !==
            {4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd10}) begin
            miss++;
            $display("FAIL lose_hold: got st=%0d lose=%b win=%b turns=%b%b rdy=%b my=%0d en=%0d want 12 1 0 00 0 0 10",
                     state_out, lose, win, my_turn, en_turn, ready1, my_ctr, en_ctr);
        end
    endtask

    task automatic test_rst_mid_game;
        logic [48:0] got;
        restart_to_wait_peer();
        ready2 = 1'b1;
        tick();
        ready2 = 1'b0;
        en_grid_cords = 8'h11;
        tick();
        en_grid_cords = 8'hFF;
        tick();
        tick();
        vec++;
        if (state_out !== 4'd9) begin
            miss++;
            $display("FAIL pre_rst_state: got %0d want 9", state_out);
        end
        rst = 1'b1;
        tick();
        got = {state_out, ship_cords_out, my_mem_addr, en_mem_addr, en_ctr, my_ctr,
               my_mem_data_out, my_mem_w_nr, en_mem_data_out, en_mem_w_nr,
               hit1, ready1, start_btn_en, my_turn, en_turn, win, lose};
        vec++;
        if (got !== {4'd0, 24'hFFFFFF, 4'd10, 4'd0, 13'd0}) begin
            miss++;
            $display("FAIL mid_rst_values: got %h want %h", got, {4'd0, 24'hFFFFFF, 4'd10, 4'd0, 13'd0});
        end
        rst = 1'b0;
        tick();
        tick();
        vec++;
        if ({state_out, my_ctr, ready1} !== {4'd0, 4'd0, 1'b0}) begin
            miss++;
            $display("FAIL post_rst_idle: got st=%0d ctr=%0d rdy=%b want 0 0 0", state_out, my_ctr, ready1);
        end
    endtask

    initial begin
        test_reset();
        test_deploy();
        test_start();
        test_timeout();
        test_enemy_shots();
        test_win();
        test_lose();
        test_rst_mid_game();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/game_fsm.md
Name: game_fsm

Overview:
- Parametrised successor of the two-player warships main controller.
- Owns ship deployment, the turn protocol with the peer board, and hit bookkeeping in both board memories ("my" and "enemy").
- Adds over the current controller:
  - board size, ship count and first-player parameters;
  - duplicate-placement rejection and repeated-shot filtering;
  - an answer timeout with shot retransmission.
- Sits between the grid/mouse decoders, the two board_mem instances and the inter-board link.

Parameters:
CORD_W, 4, bits per axis; cords = {x,y}, width 2*CORD_W; all-ones = "no selection".
SHIPS_NUMBER, 10, ships to deploy; also the initial life count on each side.
FIRST_SHOT, 1, 1: this side shoots first after start; 0: this side waits for the enemy.
TIMEOUT_CYCLES, 1_000_000, cycles in WAIT_ANSWER before the shot is retransmitted.
CTR_W, $clog2(SHIPS_NUMBER+1), counter width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
my_grid_cords  in  2*CORD_W  cell clicked on own board, all-ones = none
en_grid_cords  in  2*CORD_W  cell clicked on enemy board, all-ones = none
my_mem_addr  out  2*CORD_W  own board_mem address
my_mem_data_in  in  2  own board_mem read data, 1-cycle latency
my_mem_data_out  out  2  own board_mem write data
my_mem_w_nr  out  1  own board_mem write strobe (1 = write)
en_mem_addr, en_mem_data_in, en_mem_data_out, en_mem_w_nr  as above, enemy board
ship_cords_in  in  2*CORD_W  peer shot / answer cords, valid when ready2=1
hit2  in  1  peer answer: 1 = our shot hit
ready2  in  1  peer strobe, 1 cycle
ship_cords_out  out  2*CORD_W  our shot cords
hit1  out  1  our answer to the peer shot
ready1  out  1  our strobe, 1 cycle
start_btn  in  1  start request
start_btn_en  out  1  start allowed
my_turn, en_turn  out  1  turn indicators, mutually exclusive
win, lose  out  1  sticky end flags
my_ctr, en_ctr  out  CTR_W  own ships placed/remaining; enemy ships remaining
state_out  out  4  current state code, debug

Behaviour:
- Cell codes: EMPTY=00, SHIP=01, HIT=10, MISS=11.
- Reset: all outputs 0 except:
  - ship_cords_out, my_mem_addr, en_mem_addr = all-ones;
  - en_ctr = SHIPS_NUMBER.
  - State DEPLOY; the peer_ready latch is cleared.
  - Reset mid-game returns to DEPLOY; memory contents are not cleared by this block.
- peer_ready latch: set by ready2 in any state before the game starts.
- DEPLOY:
  - my_grid_cords != none and my_ctr < SHIPS_NUMBER: drive addr -> DEPLOY_CHECK.
  - Next cycle, if data == EMPTY: write SHIP (w_nr=1, one cycle) and my_ctr++.
  - Otherwise no write (duplicate rejected). Return to DEPLOY.
  - When my_ctr == SHIPS_NUMBER -> WAIT_START.
- WAIT_START:
  - start_btn_en = 1.
  - start_btn: ready1 pulses 1 cycle -> WAIT_PEER.
- WAIT_PEER:
  - peer_ready (or ready2 this cycle) -> WAIT_SHOT if FIRST_SHOT else WAIT_ENEMY.
- WAIT_ENEMY:
  - en_turn = 1.
  - ready2 latches ship_cords_in; my_mem_addr = cords -> MEM_CHECK (data valid this cycle).
- MEM_CHECK:
  - SHIP: write HIT, hit1 = 1, my_ctr--.
  - EMPTY: write MISS, hit1 = 0.
  - HIT/MISS (repeat shot): no write, hit1 = 0, no counter change.
  - -> ANSWER.
- ANSWER:
  - ready1 pulses with hit1 and ship_cords_out = latched cords.
  - If my_ctr == 0 -> LOSE, else WAIT_SHOT.
- WAIT_SHOT:
  - my_turn = 1.
  - en_grid_cords != none: read enemy cell -> SHOT_CHECK.
  - Next cycle, if data != EMPTY the click is ignored -> WAIT_SHOT.
  - Otherwise ship_cords_out = cords, ready1 pulse -> WAIT_ANSWER; the timeout counter clears.
- WAIT_ANSWER:
  - ready2 -> SAVE_RESULT.
  - Timeout counter reaching TIMEOUT_CYCLES-1 re-pulses ready1 with the same cords and clears the counter.
  - ready2 and timeout in the same cycle: ready2 wins, no retransmit.
- SAVE_RESULT:
  - Write en cell HIT if hit2, else MISS; en_ctr-- on hit.
  - en_ctr == 0 -> WIN, else WAIT_ENEMY.
- WIN / LOSE: terminal until rst; win/lose held 1, turns 0, all strobes 0.
- Counters never wrap: decrement at 0 and increment at SHIPS_NUMBER are blocked.
- All outputs are registered; every memory write is a single-cycle w_nr pulse.

Decomposition:
- game_pkg holds:
  - cell-code constants;
  - state enum (4-bit, codes 0..12 in the order above, fixed for state_out);
  - NO_CORD helper.
- One sub-module: turn_timer (counter, clear, expire pulse), parametrised by TIMEOUT_CYCLES.

Test Plan:
1. Deploy 10 ships at cords 00..09, then click 03 again -> my_ctr = 10, the duplicate causes no write, start_btn_en = 1.
2. ready2 during deploy, then start_btn with FIRST_SHOT=1 -> one ready1 pulse, then WAIT_SHOT with my_turn = 1.
3. Enemy shot ship_cords_in=8'h05 (data 01), then 8'h05 again (data 10):
   - first shot -> write 10, hit1 = 1, my_ctr = 9;
   - second shot -> no write, hit1 = 0, my_ctr = 9.
4. Our click 8'h11 on EMPTY, no ready2 for TIMEOUT_CYCLES (set 16) -> ready1 re-pulses at cycle 16 with cords 8'h11; then ready2 with hit2=1 -> en cell 10, en_ctr = 9.
5. en_ctr = 1, answer hit2=1 -> WIN, win = 1 held. Separately: my_ctr = 1 and the enemy hits the last ship -> ANSWER pulse, then LOSE.
6. rst asserted in WAIT_ANSWER -> next cycle DEPLOY, all outputs at reset values, en_ctr = 10.
